data_mem_log: RTL and testbench
===============================

// Module: data_mem_log
// PURPOSE
// Verification data-memory model: byte-granular write log of parametrised depth/width
// with pipelined read response. Sits on the core data port in the formal/sim harness.
// Exposes the log contents (addr/byte/valid) for contract checking.
// Generalises the fixed 32-entry log: adds validity, reset, programmable latency and fill.
// PARAMETERS
// DEPTH    32          log entries (bytes); >=4
// AW       32          byte-address width
// DW       32          data width; multiple of 8; NB = DW/8 lanes
// LATENCY  1           accept-to-rvalid cycles; >=1
// FILL     8'h00       byte returned for an address with no log hit
// PORTS
// clk_i          in   1          clock; all state updates on posedge
// rst_i          in   1          synchronous active-high reset
// data_req_i     in   1          request
// data_we_i      in   1          1=write, 0=read
// data_be_i      in   NB         byte enables; lane k addresses data_addr_i+k
// data_addr_i    in   AW         byte address
// data_wdata_i   in   DW         write data; lane k = bits [8k+7:8k]
// data_gnt_o     out  1          grant; = data_req_i (combinational)
// data_rvalid_o  out  1          read response valid
// data_rdata_o   out  DW         read data; valid with data_rvalid_o
// data_err_o     out  1          error response
// mem_addr_o     out  DEPTH*AW   log addresses, entry i at [i*AW +: AW]; i=DEPTH-1 newest
// mem_data_o     out  DEPTH*8    log bytes, same indexing
// mem_valid_o    out  DEPTH      entry valid
// count_o        out  $clog2(DEPTH+1) valid entries, saturates at DEPTH
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): all mem_valid_o=0, mem_addr_o/mem_data_o=0, count_o=0,
//   response pipeline flushed; data_rvalid_o=0, data_rdata_o=0, data_err_o=0 next cycle.
// - Accept = data_req_i & data_gnt_o & !rst_i; one request per cycle, no backpressure.
// - Write accept: each enabled lane k, in ascending k, shifts one entry into the log at
//   DEPTH-1 (all entries move down; entry 0 evicted), {valid=1, addr=data_addr_i+k, byte}.
//   All popcount(be) bytes inserted in the same cycle. be=0 write: no-op, no response.
// - Address arithmetic: data_addr_i+k truncated to AW bits (wraps 2^AW-1 -> 0).
// - Read accept: lane k with be[k]=1 returns byte of highest-index valid entry whose addr
//   equals data_addr_i+k; no hit -> FILL; lanes with be[k]=0 return 8'h00.
//   Lookup uses log state at accept edge (write in cycle N visible to read in N+1).
// - Read response: data_rvalid_o high exactly LATENCY cycles after accept, one cycle per
//   read; back-to-back reads give back-to-back responses; data_rdata_o=0 when rvalid=0.
// - count_o increments by popcount(be) per write, saturating at DEPTH.
// - Reset mid-flight: in-flight responses dropped, no rvalid emitted for them.
// - data_err_o: 0 unless CONFIGURATION feature enabled.
// CONFIGURATION
// DATA_MEM_ALIGN_CHK_EN defined: access is misaligned if addr mod NB != 0 or be not
//   contiguous; misaligned write is not logged and pulses data_err_o LATENCY cycles later
//   (rvalid=0); misaligned read returns rvalid=1, data_err_o=1, rdata=0 in its slot.
// Undefined: data_err_o tied 0; all accesses processed as above.
// TESTING (DEPTH=8, DW=32, LATENCY=2, FILL=8'hA5 unless stated)
// 1 reset; read 0x100 be=1111 -> rvalid 2 cycles later, rdata=0xA5A5A5A5, count_o=0.
// 2 write 0x100 0x11223344 be=1111; write 0x101 0x000000EE be=0001; read 0x100 be=1111
//   -> rdata=0x1122EE44, count_o=5.
// 3 write 0x200/0x204 be=1111 then 0x208 be=0001 (9 bytes) -> byte 0x200 evicted; read
//   0x200 be=1111 -> 0xXXXXXXA5 with upper bytes from write; count_o=8.
// 4 write 0xFFFFFFFE 0xDDCCBBAA be=1111 -> entries 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1;
//   read 0x0 be=0011 -> rdata=0x0000DDCC.
// 5 read accepted, rst_i=1 next cycle -> no rvalid ever for it; count_o=0, mem_valid_o=0.
// 6 ALIGN_CHK_EN: read 0x102 be=1111 -> rvalid=1, err=1, rdata=0; write 0x101 be=1111
//   -> err pulse at +2, count_o unchanged. Without macro: same write logs 4 bytes, err=0.

Source files
------------

// File: rtl/data_mem_log.sv
// data_mem_log: byte-granular write log with pipelined read response.
// Optional DATA_MEM_ALIGN_CHK_EN: flag misaligned / non-contiguous accesses.
module data_mem_log #(
    parameter int          DEPTH   = 32,
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int          LATENCY = 1,
    parameter logic [7:0]  FILL    = 8'h00,
    localparam int         NB      = DW / 8,
    localparam int         CW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [NB-1:0]         data_be_i,
    input  logic [AW-1:0]         data_addr_i,
    input  logic [DW-1:0]         data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DW-1:0]         data_rdata_o,
    output logic                  data_err_o,
    output logic [DEPTH*AW-1:0]   mem_addr_o,
    output logic [DEPTH*8-1:0]    mem_data_o,
    output logic [DEPTH-1:0]      mem_valid_o,
    output logic [CW-1:0]         count_o
);

    logic [AW-1:0]      r_addr [DEPTH];
    logic [7:0]         r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [CW-1:0]      r_count;

    logic [DW-1:0]      r_pdata [LATENCY];
    logic [LATENCY-1:0] r_pvalid;
    logic [LATENCY-1:0] r_perr;

    logic               w_acc;
    logic               w_rd;
    logic               w_wr;
    logic               w_mis;
    logic               w_log;
    logic [AW-1:0]      w_addr_n [DEPTH];
    logic [7:0]         w_data_n [DEPTH];
    logic [DEPTH-1:0]   w_valid_n;
    logic [7:0]         w_lane [NB];
    logic [DW-1:0]      w_rdata;
    logic [CW:0]        w_sum;
    logic [CW-1:0]      w_count_n;
    logic               w_s0_v;
    logic               w_s0_e;
    logic [DW-1:0]      w_s0_d;

    assign data_gnt_o = data_req_i;
    assign w_acc      = data_req_i & data_gnt_o & ~rst_i;
    assign w_rd       = w_acc & ~data_we_i;
    assign w_wr       = w_acc & data_we_i & (|data_be_i);

`ifdef DATA_MEM_ALIGN_CHK_EN
    logic [NB-1:0] w_low;
    logic          w_contig;
    logic          w_unal;

    // Adding the lowest set bit collapses a single run of ones to zero.
    assign w_low    = data_be_i & (~data_be_i + NB'(1));
    assign w_contig = ((data_be_i + w_low) & data_be_i) == '0;
    assign w_unal   = (data_addr_i % AW'(NB)) != '0;
    assign w_mis    = w_unal | ~w_contig;
`else
    assign w_mis    = 1'b0;
`endif

    assign w_log = w_wr & ~w_mis;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_addr_n[i] = r_addr[i];
            w_data_n[i] = r_data[i];
        end
        w_valid_n = r_valid;
        for (int k = 0; k < NB; k++) begin
            if (data_be_i[k]) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    w_addr_n[i]  = w_addr_n[i+1];
                    w_data_n[i]  = w_data_n[i+1];
                    w_valid_n[i] = w_valid_n[i+1];
                end
                w_addr_n[DEPTH-1]  = data_addr_i + AW'(k);
                w_data_n[DEPTH-1]  = data_wdata_i[8*k +: 8];
                w_valid_n[DEPTH-1] = 1'b1;
            end
        end
    end

    // Later (higher-index) hits override earlier ones: newest byte wins.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NB; k++) begin
            w_lane[k] = 8'h00;
            if (data_be_i[k]) begin
                w_lane[k] = FILL;
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_valid[i] && (r_addr[i] == data_addr_i + AW'(k))) begin
                        w_lane[k] = r_data[i];
                    end
                end
            end
            w_rdata[8*k +: 8] = w_lane[k];
        end
    end

    always_comb begin
        w_sum     = {1'b0, r_count} + (CW+1)'($countones(data_be_i));
        w_count_n = r_count;
        if (w_log) begin
            if (w_sum > (CW+1)'(DEPTH)) begin
                w_count_n = CW'(DEPTH);
            end else begin
                w_count_n = w_sum[CW-1:0];
            end
        end
    end

    assign w_s0_v = w_rd;
    assign w_s0_e = (w_rd | w_wr) & w_mis;
    assign w_s0_d = (w_rd & ~w_mis) ? w_rdata : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_valid  <= '0;
            r_count  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pdata[i] <= '0;
            end
            r_pvalid <= '0;
            r_perr   <= '0;
        end else begin
            if (w_log) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_addr[i] <= w_addr_n[i];
                    r_data[i] <= w_data_n[i];
                end
                r_valid <= w_valid_n;
            end
            r_count     <= w_count_n;
            r_pdata[0]  <= w_s0_d;
            r_pvalid[0] <= w_s0_v;
            r_perr[0]   <= w_s0_e;
            for (int i = 1; i < LATENCY; i++) begin
                r_pdata[i]  <= r_pdata[i-1];
                r_pvalid[i] <= r_pvalid[i-1];
                r_perr[i]   <= r_perr[i-1];
            end
        end
    end

    assign data_rvalid_o = r_pvalid[LATENCY-1];
    assign data_rdata_o  = r_pdata[LATENCY-1];
    assign data_err_o    = r_perr[LATENCY-1];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_addr_o[i*AW +: AW] = r_addr[i];
            mem_data_o[i*8 +: 8]   = r_data[i];
        end
    end

    assign mem_valid_o = r_valid;
    assign count_o     = r_count;

endmodule

// File: tb/tb_data_mem_log.sv
// Directed bench for data_mem_log with a response scoreboard.
// Expectations for the alignment checker follow DATA_MEM_ALIGN_CHK_EN.
module tb_data_mem_log;

    localparam int         DEPTH = 8;
    localparam int         AW    = 32;
    localparam int         DW    = 32;
    localparam int         LAT   = 2;
    localparam logic [7:0] FILL  = 8'hA5;
    localparam int         NB    = DW / 8;
    localparam int         CW    = $clog2(DEPTH + 1);

`ifdef DATA_MEM_ALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req = 1'b0;
    logic                we  = 1'b0;
    logic [NB-1:0]       be  = '0;
    logic [AW-1:0]       addr = '0;
    logic [DW-1:0]       wdata = '0;
    logic                gnt;
    logic                rvalid;
    logic [DW-1:0]       rdata;
    logic                err;
    logic [DEPTH*AW-1:0] mem_addr;
    logic [DEPTH*8-1:0]  mem_data;
    logic [DEPTH-1:0]    mem_valid;
    logic [CW-1:0]       count;

    data_mem_log #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .LATENCY(LAT), .FILL(FILL)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata),
        .data_gnt_o(gnt), .data_rvalid_o(rvalid),
        .data_rdata_o(rdata), .data_err_o(err),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .mem_valid_o(mem_valid), .count_o(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          e;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] m_addr[$];
    logic [7:0]    m_data[$];
    int            cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit contig(input logic [NB-1:0] b);
        int  runs = 0;
        bit  prev = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (b[i] && !prev) runs++;
            prev = b[i];
        end
        return runs <= 1;
    endfunction

    function automatic logic [7:0] m_lookup(input logic [AW-1:0] a);
        logic [7:0] r = FILL;
        for (int i = 0; i < m_addr.size(); i++) begin
            if (m_addr[i] == a) r = m_data[i];
        end
        return r;
    endfunction

    // Monitor: every response or error pulse must match the queue head.
    always @(negedge clk) begin
        if (rvalid === 1'b1 || err === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {62'd0, rvalid, err}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rvalid", {63'd0, rvalid}, {63'd0, e.v});
                chk("err", {63'd0, err}, {63'd0, e.e});
                chk("rdata", {32'd0, rdata}, {32'd0, e.d});
            end
        end else if (rst === 1'b0) begin
            if (rdata !== '0) chk("idle_rdata", {32'd0, rdata}, 64'd0);
        end
    end

    task automatic access(input logic w, input logic [NB-1:0] b,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit push);
        exp_t e;
        bit   mis;
        @(posedge clk); #1;
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        mis = CHK_EN && (a[1:0] != 2'b00 || !contig(b));
        e.cyc = cyc + LAT;
        if (w) begin
            if (b != '0) begin
                if (mis) begin
                    e.v = 1'b0; e.e = 1'b1; e.d = '0;
                    if (push) sb.push_back(e);
                end else begin
                    for (int k = 0; k < NB; k++) begin
                        if (b[k]) begin
                            m_addr.push_back(a + AW'(k));
                            m_data.push_back(d[8*k +: 8]);
                            if (m_addr.size() > DEPTH) begin
                                void'(m_addr.pop_front());
                                void'(m_data.pop_front());
                            end
                        end
                    end
                end
            end
        end else begin
            e.v = 1'b1; e.e = mis; e.d = '0;
            if (!mis) begin
                for (int k = 0; k < NB; k++) begin
                    if (b[k]) e.d[8*k +: 8] = m_lookup(a + AW'(k));
                end
            end
            if (push) sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; be = '0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0; we = 1'b0; be = '0;
        m_addr.delete();
        m_data.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_log(input string tag);
        int n;
        int j;
        logic [DEPTH-1:0] v_exp;
        n = m_addr.size();
        v_exp = '0;
        chk({tag, "_count"}, 64'(count), 64'(n));
        for (int i = 0; i < n; i++) begin
            j = DEPTH - n + i;
            v_exp[j] = 1'b1;
            chk({tag, "_addr"}, 64'(mem_addr[j*AW +: AW]), 64'(m_addr[i]));
            chk({tag, "_byte"}, 64'(mem_data[j*8 +: 8]), 64'(m_data[i]));
        end
        chk({tag, "_valid"}, 64'(mem_valid), 64'(v_exp));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state and a miss read
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("gnt_follows_req", {63'd0, gnt}, {63'd0, req});
        access(1'b0, 4'b1111, 32'h100, '0, 1'b1);
        chk("gnt_high", {63'd0, gnt}, 64'd1);
        idle();
        drain("t1_drain");
        check_log("t1");

        // 2: overlapping writes, newest byte wins
        access(1'b1, 4'b1111, 32'h100, 32'h11223344, 1'b1);
        access(1'b1, 4'b0001, 32'h101, 32'h000000EE, 1'b1);
        access(1'b0, 4'b1111, 32'h100, '0, 1'b1);
        idle();
        drain("t2_drain");
        check_log("t2");

        // 3: eviction of the oldest bytes, count saturates
        access(1'b1, 4'b1111, 32'h200, 32'h44332211, 1'b1);
        access(1'b1, 4'b1111, 32'h204, 32'h88776655, 1'b1);
        access(1'b1, 4'b0001, 32'h208, 32'h00000099, 1'b1);
        access(1'b0, 4'b1111, 32'h200, '0, 1'b1);
        access(1'b0, 4'b0000, 32'h204, '0, 1'b1);
        access(1'b1, 4'b0000, 32'h300, 32'hFFFFFFFF, 1'b1);
        idle();
        drain("t3_drain");
        check_log("t3");

        // 4: address wrap and partial lanes
        do_reset();
        access(1'b1, 4'b1111, 32'hFFFFFFFE, 32'hDDCCBBAA, 1'b1);
        access(1'b0, 4'b0011, 32'h0, '0, 1'b1);
        access(1'b0, 4'b1100, 32'hFFFFFFFC, '0, 1'b1);
        idle();
        drain("t4_drain");
        check_log("t4");

        // 5: reset drops an in-flight read
        access(1'b0, 4'b1111, 32'h0, '0, 1'b0);
        do_reset();
        repeat (LAT + 3) @(posedge clk);
        #1;
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_valid", 64'(mem_valid), 64'd0);

        // 6: misaligned accesses
        access(1'b1, 4'b1111, 32'h100, 32'h0A0B0C0D, 1'b1);
        access(1'b0, 4'b1111, 32'h102, '0, 1'b1);
        access(1'b1, 4'b1111, 32'h101, 32'h51525354, 1'b1);
        access(1'b0, 4'b1010, 32'h100, '0, 1'b1);
        access(1'b0, 4'b0110, 32'h100, '0, 1'b1);
        idle();
        drain("t6_drain");
        check_log("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
